modaddsub_sequencer: RTL and testbench
======================================

Name: modaddsub_sequencer

Overview:
- Sequences the dual-rail modular adder/subtractor datapath (first stage plus downstream stages) and shares it between two requesters.
- Arbitrates requests round-robin and range-checks operands against the modulus.
- Drives the datapath operand and mode inputs, then waits for dual-rail completion on the first-stage rails.
- Captures the final-stage result and returns it, with a status code, over a valid/ready response channel.

Parameters:
- MOD, 11, modulus; operands must satisfy 0 <= x,y < MOD.
- SETTLE_MIN, 2, cycles the datapath inputs are held before completion sampling starts (1..15).
- TIMEOUT, 15, maximum completion-wait cycles after SETTLE_MIN before an error is returned (1..255).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_s  in  1  0 = add, 1 = subtract.
- req0_x  in  4  operand x.
- req0_y  in  4  operand y.
- req1_valid, req1_ready, req1_s, req1_x, req1_y: same as requester 0.
- dp_s  out  1  datapath mode.
- dp_x  out  4  datapath operand x3..x0.
- dp_y  out  4  datapath operand y3..y0.
- dp_rail  in  16  first-stage dual-rail pairs, order {b4,a3,b3,a2,b2,a1,b1,a0}, each pair {_0,_1}; bit 15 = b4_0, bit 0 = a0_1.
- dp_result  in  4  final-stage binary result.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester that issued the operation.
- rsp_result  out  4  result; 0 unless rsp_err == 00.
- rsp_err  out  2  00 ok, 01 operand range, 10 rail code violation, 11 timeout.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous active-low on rst_n.
- Reset values: all outputs 0; state IDLE; round-robin pointer last = 1, so requester 0 wins first.
- States: IDLE, CHECK, SETTLE, WAIT, RESP.
- IDLE, arbitration:
  - Grant goes to the requester with valid high.
  - If both are valid, grant goes to the requester != last.
  - reqN_ready = (state == IDLE) && grantN; combinational, at most one ready high.
  - On valid & ready: register s, x, y and id; set last = id; go to CHECK.
- CHECK (1 cycle):
  - If x >= MOD or y >= MOD: rsp_err = 01, go to RESP. The datapath is not driven and dp_* keep their previous values.
  - Else load dp_s/dp_x/dp_y from the registers, clear the counter, go to SETTLE.
- SETTLE: hold dp_* and count. After SETTLE_MIN cycles in SETTLE, go to WAIT with the counter cleared.
- WAIT: each cycle, evaluate dp_rail as registered inputs. Priority order:
  - (a) Any pair == 11: rsp_err = 10, result 0, go to RESP.
  - (b) Every pair is 01 or 10: capture dp_result into rsp_result, rsp_err = 00, go to RESP.
  - (c) Counter == TIMEOUT-1: rsp_err = 11, go to RESP.
  - (d) Otherwise increment the counter.
  - A pair == 00 is spacer (incomplete), not an error.
- dp_* hold their last driven values from CHECK until the next successful CHECK.
- RESP:
  - rsp_valid high; rsp_id/result/err stable while rsp_valid && !rsp_ready.
  - On rsp_ready: rsp_valid drops on the next cycle, go to IDLE.
  - No request is accepted in the same cycle as a response handshake.
  - Minimum turnaround, valid request to next acceptance: SETTLE_MIN + 4 cycles with rsp_ready held high.
- Reference model for an ok result: s = 0 gives (x + y) mod MOD; s = 1 gives (x - y + MOD) mod MOD. The sequencer does not compute this; the bench uses it to check the datapath plus sequencer.
- Reset mid-operation: state returns to IDLE immediately and asynchronously, with all outputs at reset values. A pending response is discarded; requesters must reissue.
- Requester valid dropping before ready: no effect. An operation is captured only on a valid & ready cycle.

Test Plan:
- Add, requester 0 only: s=0, x=7, y=6, stub datapath returns all-valid rails and result 2 after 1 WAIT cycle. Required: rsp_valid with id=0, result=2, err=00; busy high from CHECK through RESP.
- Subtract wrap: req1 s=1, x=3, y=5, result 9. Required: id=1, result=9, err=00; dp_s=1, dp_x=3, dp_y=5 held through SETTLE and WAIT.
- Contention: both valid continuously with distinct operands over 4 operations. Required: grants alternate 0,1,0,1; req ready never high for both in one cycle.
- Range error: x=11, y=0. Required: err=01, result=0, no change on dp_* from the previous values; response arrives 2 cycles after acceptance.
- Rail faults: (a) pair b2 forced to 11 in WAIT gives err=10; (b) pair a0 held 00 gives err=11 after exactly TIMEOUT WAIT cycles.
- Back-pressure and reset: rsp_ready low for 5 cycles keeps rsp fields stable and blocks new requests. Then rst_n pulsed low mid-WAIT: all outputs read 0 asynchronously, state IDLE, next grant goes to requester 0.

Source files
------------

// File: rtl/modaddsub_sequencer.sv
// modaddsub_sequencer: shares a dual-rail modular add/sub datapath between two requesters
module modaddsub_sequencer #(
    parameter int MOD        = 11,
    parameter int SETTLE_MIN = 2,
    parameter int TIMEOUT    = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_s,
    input  logic [3:0]  req0_x,
    input  logic [3:0]  req0_y,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_s,
    input  logic [3:0]  req1_x,
    input  logic [3:0]  req1_y,
    output logic        dp_s,
    output logic [3:0]  dp_x,
    output logic [3:0]  dp_y,
    input  logic [15:0] dp_rail,
    input  logic [3:0]  dp_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [3:0]  rsp_result,
    output logic [1:0]  rsp_err,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, CHECK, SETTLE, WAIT, RESP} state_t;

    localparam logic [4:0] MOD_W    = 5'(MOD);
    localparam logic [7:0] SET_LAST = 8'(SETTLE_MIN - 1);
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

    state_t     state, state_nx;
    logic       s_r, id_r, last;
    logic [3:0] x_r, y_r;
    logic [7:0] cnt;
    logic [7:0] rail_hi, rail_lo;
    logic       grant1, accept, range_bad, rail_any11, rail_done, wait_end;

    // Split the rail bus into the _0 and _1 halves of each pair
    always_comb begin
        rail_hi = '0;
        rail_lo = '0;
        for (int i = 0; i < 8; i++) begin
            rail_hi[i] = dp_rail[2*i+1];
            rail_lo[i] = dp_rail[2*i];
        end
    end

    assign rail_any11 = |(rail_hi & rail_lo);
    assign rail_done  = &(rail_hi ^ rail_lo);
    assign wait_end   = rail_any11 || rail_done || cnt == TO_LAST;
    assign range_bad  = {1'b0, x_r} >= MOD_W || {1'b0, y_r} >= MOD_W;
    assign grant1     = req1_valid && (!req0_valid || !last);
    assign accept     = req0_ready || req1_ready;
    assign busy       = state != IDLE;

    // State register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    // Next-state and round-robin ready generation
    always_comb begin
        state_nx   = state;
        req0_ready = state == IDLE && req0_valid && !grant1;
        req1_ready = state == IDLE && grant1;
        case (state)
            IDLE:    state_nx = accept ? CHECK : IDLE;
            CHECK:   state_nx = range_bad ? RESP : SETTLE;
            SETTLE:  state_nx = cnt == SET_LAST ? WAIT : SETTLE;
            WAIT:    state_nx = wait_end ? RESP : WAIT;
            RESP:    state_nx = rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    // Operation capture, datapath drive, completion sampling and response registers
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s_r        <= 1'b0;
            x_r        <= '0;
            y_r        <= '0;
            id_r       <= 1'b0;
            last       <= 1'b1;
            cnt        <= '0;
            dp_s       <= 1'b0;
            dp_x       <= '0;
            dp_y       <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    s_r  <= grant1 ? req1_s : req0_s;
                    x_r  <= grant1 ? req1_x : req0_x;
                    y_r  <= grant1 ? req1_y : req0_y;
                    id_r <= grant1;
                    last <= grant1;
                end
                CHECK: if (range_bad) begin
                    rsp_valid  <= 1'b1;
                    rsp_id     <= id_r;
                    rsp_err    <= 2'b01;
                    rsp_result <= '0;
                end else begin
                    dp_s <= s_r;
                    dp_x <= x_r;
                    dp_y <= y_r;
                    cnt  <= '0;
                end
                SETTLE: cnt <= cnt == SET_LAST ? 8'd0 : cnt + 8'd1;
                WAIT: if (wait_end) begin
                    rsp_valid  <= 1'b1;
                    rsp_id     <= id_r;
                    rsp_err    <= rail_any11 ? 2'b10 : rail_done ? 2'b00 : 2'b11;
                    rsp_result <= (!rail_any11 && rail_done) ? dp_result : 4'd0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                RESP: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
endmodule

// File: tb/tb_modaddsub_sequencer.sv
// tb_modaddsub_sequencer: scoreboard bench with a stub dual-rail datapath
module tb_modaddsub_sequencer;
    localparam int MOD = 11, SM = 2, TO = 15;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req0_valid = 0, req0_s = 0, req1_valid = 0, req1_s = 0;
    logic [3:0]  req0_x = 0, req0_y = 0, req1_x = 0, req1_y = 0;
    logic        req0_ready, req1_ready, dp_s, rsp_valid, rsp_id, busy;
    logic        rsp_ready = 1'b0;
    logic [3:0]  dp_x, dp_y, dp_result, rsp_result;
    logic [15:0] dp_rail;
    logic [1:0]  rsp_err;
    logic [1:0]  rail_mode = 2'd0;

    typedef struct {logic id; logic [3:0] res; logic [1:0] err;} exp_t;
    exp_t exp_q[$];
    exp_t e;
    int checks = 0, failures = 0;

    modaddsub_sequencer #(.MOD(MOD), .SETTLE_MIN(SM), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_s(req0_s), .req0_x(req0_x), .req0_y(req0_y),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_s(req1_s), .req1_x(req1_x), .req1_y(req1_y),
        .dp_s(dp_s), .dp_x(dp_x), .dp_y(dp_y), .dp_rail(dp_rail), .dp_result(dp_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ref_op(input logic s, input logic [3:0] x, input logic [3:0] y);
        int r;
        r = s ? (int'(x) - int'(y) + MOD) % MOD : (int'(x) + int'(y)) % MOD;
        return 4'(r);
    endfunction

    // Stub datapath: mode 0 all pairs valid, 1 pair b2 = 11, 2 pair a0 spacer, 3 all spacer
    always_comb begin
        dp_result = ref_op(dp_s, dp_x, dp_y);
        dp_rail   = 16'h5555;
        if (rail_mode == 2'd1) dp_rail[7:6] = 2'b11;
        if (rail_mode == 2'd2) dp_rail[1:0] = 2'b00;
        if (rail_mode == 2'd3) dp_rail = 16'h0000;
    end

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic issue(input bit id, input bit s, input logic [3:0] x, input logic [3:0] y,
                         output bit ok, output int w);
        ok = 0;
        w = 0;
        if (id) begin req1_s = s; req1_x = x; req1_y = y; req1_valid = 1; end
        else    begin req0_s = s; req0_x = x; req0_y = y; req0_valid = 1; end
        for (int i = 0; i < 60; i++) begin
            #1;
            if (id ? req1_ready : req0_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
            w++;
        end
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
        end
        if (id) req1_valid = 0; else req0_valid = 0;
    endtask

    // Cycle index of rsp_valid counted from the acceptance cycle (0)
    task automatic get_rsp(output bit ok, output int cyc);
        ok = 0;
        cyc = 1;
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid) begin
                ok = 1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic ack_rsp();
        rsp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({req0_ready, req1_ready, dp_s, dp_x, dp_y, rsp_valid, rsp_id, rsp_result, rsp_err, busy} !== 23'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {req0_ready, req1_ready, dp_s, dp_x, dp_y, rsp_valid, rsp_id, rsp_result, rsp_err, busy});
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_add();
        bit ok; int w, cyc;
        rail_mode = 0;
        issue(0, 0, 4'd7, 4'd6, ok, w);
        exp_q.push_back('{1'b0, ref_op(0, 4'd7, 4'd6), 2'b00});
        checks++;
        if (!ok || busy !== 1'b1) begin
            failures++;
            $display("FAIL add_accept: ok=%0d busy=%b expected ok=1 busy=1", ok, busy);
        end
        get_rsp(ok, cyc);
        e = exp_q.pop_front();
        checks++;
        if (!ok || cyc != SM + 3 || busy !== 1'b1) begin
            failures++;
            $display("FAIL add_latency: ok=%0d cycle=%0d busy=%b expected cycle=%0d busy=1", ok, cyc, busy, SM + 3);
        end
        checks++;
        if ({rsp_id, rsp_result, rsp_err} !== {e.id, e.res, e.err}) begin
            failures++;
            $display("FAIL add_rsp: got id=%b res=%0d err=%b expected id=%b res=%0d err=%b",
                     rsp_id, rsp_result, rsp_err, e.id, e.res, e.err);
        end
        ack_rsp();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL add_release: rsp_valid=%b busy=%b expected 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_sub_wrap();
        bit ok; int w, cyc;
        issue(1, 1, 4'd3, 4'd5, ok, w);
        exp_q.push_back('{1'b1, ref_op(1, 4'd3, 4'd5), 2'b00});
        @(negedge clk);
        checks++;
        if ({dp_s, dp_x, dp_y} !== {1'b1, 4'd3, 4'd5}) begin
            failures++;
            $display("FAIL sub_dp_settle: got s=%b x=%0d y=%0d expected 1 3 5", dp_s, dp_x, dp_y);
        end
        get_rsp(ok, cyc);
        e = exp_q.pop_front();
        checks++;
        if (!ok || {rsp_id, rsp_result, rsp_err} !== {e.id, e.res, e.err}) begin
            failures++;
            $display("FAIL sub_rsp: ok=%0d got id=%b res=%0d err=%b expected id=%b res=%0d err=%b",
                     ok, rsp_id, rsp_result, rsp_err, e.id, e.res, e.err);
        end
        checks++;
        if ({dp_s, dp_x, dp_y} !== {1'b1, 4'd3, 4'd5}) begin
            failures++;
            $display("FAIL sub_dp_hold: got s=%b x=%0d y=%0d expected 1 3 5", dp_s, dp_x, dp_y);
        end
        ack_rsp();
    endtask

    task automatic test_contention();
        logic       s0[2] = '{1'b0, 1'b1}, s1[2] = '{1'b0, 1'b1};
        logic [3:0] x0[2] = '{4'd1, 4'd2}, y0[2] = '{4'd2, 4'd8};
        logic [3:0] x1[2] = '{4'd9, 4'd0}, y1[2] = '{4'd5, 4'd10};
        int k0 = 0, k1 = 0, ng = 0, nr = 0, both = 0;
        bit g[4];
        rsp_ready = 1;
        req0_s = s0[0]; req0_x = x0[0]; req0_y = y0[0]; req0_valid = 1;
        req1_s = s1[0]; req1_x = x1[0]; req1_y = y1[0]; req1_valid = 1;
        for (int c = 0; c < 300 && (ng < 4 || nr < 4); c++) begin
            #1;
            if (req0_ready && req1_ready) both++;
            if (rsp_valid) begin
                e = exp_q.pop_front();
                nr++;
                checks++;
                if ({rsp_id, rsp_result, rsp_err} !== {e.id, e.res, e.err}) begin
                    failures++;
                    $display("FAIL contention_rsp%0d: got id=%b res=%0d err=%b expected id=%b res=%0d err=%b",
                             nr, rsp_id, rsp_result, rsp_err, e.id, e.res, e.err);
                end
            end
            if ((req0_ready || req1_ready) && ng < 4) begin
                g[ng] = req1_ready;
                if (req1_ready) exp_q.push_back('{1'b1, ref_op(req1_s, req1_x, req1_y), 2'b00});
                else            exp_q.push_back('{1'b0, ref_op(req0_s, req0_x, req0_y), 2'b00});
                ng++;
                @(posedge clk);
                @(negedge clk);
                if (g[ng-1]) begin k1++; req1_s = s1[k1%2]; req1_x = x1[k1%2]; req1_y = y1[k1%2]; end
                else         begin k0++; req0_s = s0[k0%2]; req0_x = x0[k0%2]; req0_y = y0[k0%2]; end
                if (ng == 4) begin req0_valid = 0; req1_valid = 0; end
            end else begin
                @(negedge clk);
            end
        end
        rsp_ready = 0;
        req0_valid = 0;
        req1_valid = 0;
        checks++;
        if (ng != 4 || nr != 4 || both != 0) begin
            failures++;
            $display("FAIL contention_count: grants=%0d rsps=%0d both_ready=%0d expected 4 4 0", ng, nr, both);
        end
        checks++;
        if ({g[0], g[1], g[2], g[3]} !== 4'b0101) begin
            failures++;
            $display("FAIL contention_order: got %b%b%b%b expected 0101", g[0], g[1], g[2], g[3]);
        end
        @(negedge clk);
    endtask

    task automatic test_range();
        bit ok; int w, cyc;
        logic [8:0] dp_before;
        dp_before = {dp_s, dp_x, dp_y};
        issue(0, 0, 4'd11, 4'd0, ok, w);
        exp_q.push_back('{1'b0, 4'd0, 2'b01});
        get_rsp(ok, cyc);
        e = exp_q.pop_front();
        checks++;
        if (!ok || cyc != 2 || {rsp_id, rsp_result, rsp_err} !== {e.id, e.res, e.err}) begin
            failures++;
            $display("FAIL range_rsp: ok=%0d cycle=%0d id=%b res=%0d err=%b expected cycle=2 id=%b res=%0d err=%b",
                     ok, cyc, rsp_id, rsp_result, rsp_err, e.id, e.res, e.err);
        end
        checks++;
        if ({dp_s, dp_x, dp_y} !== dp_before) begin
            failures++;
            $display("FAIL range_dp: got %h expected %h", {dp_s, dp_x, dp_y}, dp_before);
        end
        ack_rsp();
    endtask

    task automatic test_rail_faults();
        bit ok; int w, cyc;
        rail_mode = 1;
        issue(1, 0, 4'd1, 4'd1, ok, w);
        exp_q.push_back('{1'b1, 4'd0, 2'b10});
        get_rsp(ok, cyc);
        e = exp_q.pop_front();
        checks++;
        if (!ok || cyc != SM + 3 || {rsp_id, rsp_result, rsp_err} !== {e.id, e.res, e.err}) begin
            failures++;
            $display("FAIL rail_code: ok=%0d cycle=%0d id=%b res=%0d err=%b expected cycle=%0d id=%b res=%0d err=%b",
                     ok, cyc, rsp_id, rsp_result, rsp_err, SM + 3, e.id, e.res, e.err);
        end
        ack_rsp();
        rail_mode = 2;
        issue(0, 0, 4'd2, 4'd3, ok, w);
        exp_q.push_back('{1'b0, 4'd0, 2'b11});
        get_rsp(ok, cyc);
        e = exp_q.pop_front();
        checks++;
        if (!ok || cyc != SM + 2 + TO || {rsp_id, rsp_result, rsp_err} !== {e.id, e.res, e.err}) begin
            failures++;
            $display("FAIL rail_timeout: ok=%0d cycle=%0d id=%b res=%0d err=%b expected cycle=%0d id=%b res=%0d err=%b",
                     ok, cyc, rsp_id, rsp_result, rsp_err, SM + 2 + TO, e.id, e.res, e.err);
        end
        ack_rsp();
        rail_mode = 0;
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2; int w1, w2, cyc;
        rsp_ready = 1;
        issue(0, 0, 4'd5, 4'd5, ok1, w1);
        issue(1, 1, 4'd4, 4'd9, ok2, w2);
        exp_q.push_back('{1'b1, ref_op(1, 4'd4, 4'd9), 2'b00});
        checks++;
        if (!ok1 || !ok2 || w2 != SM + 3) begin
            failures++;
            $display("FAIL back_to_back_turnaround: ok=%0d%0d gap=%0d expected %0d", ok1, ok2, w2 + 1, SM + 4);
        end
        get_rsp(ok2, cyc);
        e = exp_q.pop_front();
        checks++;
        if (!ok2 || {rsp_id, rsp_result, rsp_err} !== {e.id, e.res, e.err}) begin
            failures++;
            $display("FAIL back_to_back_rsp: got id=%b res=%0d err=%b expected id=%b res=%0d err=%b",
                     rsp_id, rsp_result, rsp_err, e.id, e.res, e.err);
        end
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 0;
    endtask

    task automatic test_backpressure_reset();
        bit ok; int w, cyc, bad = 0;
        logic [6:0] held;
        issue(1, 1, 4'd2, 4'd7, ok, w);
        exp_q.push_back('{1'b1, ref_op(1, 4'd2, 4'd7), 2'b00});
        get_rsp(ok, cyc);
        held = {rsp_id, rsp_result, rsp_err};
        req0_valid = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            if (!rsp_valid || {rsp_id, rsp_result, rsp_err} !== held || req0_ready || req1_ready) bad++;
        end
        req0_valid = 0;
        checks++;
        if (!ok || bad != 0) begin
            failures++;
            $display("FAIL backpressure_hold: ok=%0d unstable_cycles=%0d expected 0", ok, bad);
        end
        e = exp_q.pop_front();
        checks++;
        if ({rsp_id, rsp_result, rsp_err} !== {e.id, e.res, e.err}) begin
            failures++;
            $display("FAIL backpressure_rsp: got id=%b res=%0d err=%b expected id=%b res=%0d err=%b",
                     rsp_id, rsp_result, rsp_err, e.id, e.res, e.err);
        end
        @(negedge clk);
        ack_rsp();
        rail_mode = 3;
        issue(1, 0, 4'd6, 4'd1, ok, w);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_midwait_busy: ok=%0d busy=%b expected 1 1", ok, busy);
        end
        #3 rst_n = 0;
        #1;
        checks++;
        if ({req0_ready, req1_ready, dp_s, dp_x, dp_y, rsp_valid, rsp_id, rsp_result, rsp_err, busy} !== 23'd0) begin
            failures++;
            $display("FAIL reset_async: got %h expected 0",
                     {req0_ready, req1_ready, dp_s, dp_x, dp_y, rsp_valid, rsp_id, rsp_result, rsp_err, busy});
        end
        @(negedge clk);
        rst_n = 1;
        rail_mode = 0;
        req0_s = 0; req0_x = 4'd10; req0_y = 4'd10; req0_valid = 1;
        req1_s = 1; req1_x = 4'd1;  req1_y = 4'd2;  req1_valid = 1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            failures++;
            $display("FAIL reset_grant: got r0=%b r1=%b expected 1 0", req0_ready, req1_ready);
        end
        exp_q.push_back('{1'b0, ref_op(0, 4'd10, 4'd10), 2'b00});
        @(posedge clk);
        @(negedge clk);
        req0_valid = 0;
        req1_valid = 0;
        get_rsp(ok, cyc);
        e = exp_q.pop_front();
        checks++;
        if (!ok || {rsp_id, rsp_result, rsp_err} !== {e.id, e.res, e.err}) begin
            failures++;
            $display("FAIL reset_next_rsp: ok=%0d got id=%b res=%0d err=%b expected id=%b res=%0d err=%b",
                     ok, rsp_id, rsp_result, rsp_err, e.id, e.res, e.err);
        end
        ack_rsp();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_wrap();
        test_contention();
        test_range();
        test_rail_faults();
        test_back_to_back();
        test_backpressure_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
